// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline boundary register with valid/ready handshake and a 2-entry skid buffer.
// Latency: a word accepted into an empty (or simultaneously draining) buffer is on out_* after 1 edge.
// Backpressure: in_ready = !FULL && !flush, registered state only (no combinational path from out_ready).
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               synchronous flush: empties buffer, rewinds held PC, head instr -> NOP
//   in_valid/in_ready   fetch-side handshake; in_pc/in_instr carry the fetched word
//   out_valid/out_ready decode-side handshake; out_pc/out_instr show the head entry
//   occupancy           entries held (0, 1 or 2)
module if_id_skid_reg #(
   parameter int                 PC_W         = 32,
   parameter int                 INSTR_W      = 32,
   parameter logic [INSTR_W-1:0] NOP          = '0,
   parameter int                 FLUSH_PC_DEC = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr,
   output logic [1:0]         occupancy
);

   // Encoding equals the number of entries held, so occupancy is the state itself.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [PC_W-1:0] PC_DEC = PC_W'(FLUSH_PC_DEC);

   state_t               state, state_nx;
   logic [PC_W-1:0]      head_pc, head_pc_nx;
   logic [INSTR_W-1:0]   head_instr, head_instr_nx;
   logic [PC_W-1:0]      skid_pc, skid_pc_nx;
   logic [INSTR_W-1:0]   skid_instr, skid_instr_nx;
   logic                 accept;
   logic                 pop;

   // in_ready is forced low while reset is asserted, otherwise it depends only on
   // registered state and flush.
   assign in_ready  = !rst && (state != FULL) && !flush;
   assign out_valid = (state != EMPTY);
   assign out_pc    = head_pc;
   assign out_instr = head_instr;
   assign occupancy = state;

   assign accept = in_valid && in_ready;
   assign pop    = out_valid && out_ready;

   always_comb begin
      state_nx      = state;
      head_pc_nx    = head_pc;
      head_instr_nx = head_instr;
      skid_pc_nx    = skid_pc;
      skid_instr_nx = skid_instr;

      if (flush) begin
         // Flush wins over accept/pop: any same-cycle pop is treated as consumed,
         // the skid entry is discarded and the held PC is rewound.
         state_nx      = EMPTY;
         head_pc_nx    = in_pc - PC_DEC;
         head_instr_nx = NOP;
         skid_pc_nx    = '0;
         skid_instr_nx = '0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  state_nx      = ONE;
                  head_pc_nx    = in_pc;
                  head_instr_nx = in_instr;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  head_pc_nx    = in_pc;
                  head_instr_nx = in_instr;
               end else if (accept) begin
                  state_nx      = FULL;
                  skid_pc_nx    = in_pc;
                  skid_instr_nx = in_instr;
               end else if (pop) begin
                  // Draining to empty keeps the last PC visible but blanks the instruction.
                  state_nx      = EMPTY;
                  head_instr_nx = NOP;
               end
            end
            FULL: begin
               if (pop) begin
                  state_nx      = ONE;
                  head_pc_nx    = skid_pc;
                  head_instr_nx = skid_instr;
               end
            end
            default: begin
               state_nx = EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= EMPTY;
         head_pc    <= '0;
         head_instr <= NOP;
         skid_pc    <= '0;
         skid_instr <= '0;
      end else begin
         state      <= state_nx;
         head_pc    <= head_pc_nx;
         head_instr <= head_instr_nx;
         skid_pc    <= skid_pc_nx;
         skid_instr <= skid_instr_nx;
      end
   end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Testbench for if_id_skid_reg: directed scenarios plus random traffic checked
// against a queue-based model of the buffer contents.
// A second instance with no PC rewind shares all inputs.
module tb_if_id_skid_reg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_instr = '0;

   logic        in_ready, out_valid;
   logic [31:0] out_pc, out_instr;
   logic [1:0]  occupancy;

   logic        in_ready0, out_valid0;
   logic [31:0] out_pc0, out_instr0;
   logic [1:0]  occupancy0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   if_id_skid_reg #(.PC_W(32), .INSTR_W(32), .NOP(NOP), .FLUSH_PC_DEC(1)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .occupancy(occupancy)
   );

   if_id_skid_reg #(.PC_W(32), .INSTR_W(32), .NOP(NOP), .FLUSH_PC_DEC(0)) u_dut0 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready0), .in_pc(in_pc), .in_instr(in_instr),
      .out_valid(out_valid0), .out_ready(out_ready), .out_pc(out_pc0), .out_instr(out_instr0),
      .occupancy(occupancy0)
   );

   // Reference model: ordered list of held words plus the PC shown when empty.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } word_t;

   word_t       q[$];
   logic [31:0] held_pc;

   // Previous-cycle snapshot for the hold-stability check.
   logic        prev_hold = 1'b0;
   logic [31:0] prev_pc, prev_instr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_pc();
      return (q.size() > 0) ? q[0].pc : held_pc;
   endfunction

   function automatic logic [31:0] m_instr();
      return (q.size() > 0) ? q[0].instr : NOP;
   endfunction

   task automatic model_reset();
      q.delete();
      held_pc   = '0;
      prev_hold = 1'b0;
   endtask

   // One clock cycle: apply inputs, check at the falling edge, advance the model at
   // the rising edge, return 1 time unit after it.
   task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                        input logic ordy, input logic fl);
      logic ir;
      in_valid  = v;
      in_pc     = pc;
      in_instr  = instr;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      ir = (q.size() < 2) && !fl;
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("out_pc",    out_pc,    m_pc());
      chk("out_instr", out_instr, m_instr());
      chk("occupancy", 32'(occupancy), 32'(q.size()));
      chk("in_ready",  32'(in_ready), 32'(ir));
      if (prev_hold) begin
         chk("hold_pc",    out_pc,    prev_pc);
         chk("hold_instr", out_instr, prev_instr);
      end
      prev_hold  = out_valid && !ordy && !fl;
      prev_pc    = out_pc;
      prev_instr = out_instr;
      @(posedge clk);
      if (fl) begin
         q.delete();
         held_pc = pc - 32'd1;
      end else begin
         if (q.size() > 0 && ordy) begin
            held_pc = q[0].pc;
            void'(q.pop_front());
         end
         if (v && ir) q.push_back('{pc: pc, instr: instr});
      end
      #1;
   endtask

   initial begin
      model_reset();
      // Reset values while rst is held.
      #12;
      chk("rst_in_ready",  32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pc",    out_pc, 32'd0);
      chk("rst_out_instr", out_instr, NOP);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // 1) Streaming with decode always ready: 1-cycle latency, occupancy 1.
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 32'(4 * i), 32'hA5A5_0000 + 32'(i), 1'b1, 1'b0);
         chk("s1_out_pc", out_pc, 32'(4 * i));
         chk("s1_occ",    32'(occupancy), 32'd1);
      end
      cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      chk("s1_drain_occ", 32'(occupancy), 32'd0);
      chk("s1_drain_pc",  out_pc, 32'h8);

      // 2) Backpressure fills the skid entry, then drains in order.
      cycle(1'b1, 32'h10, 32'hB0, 1'b0, 1'b0);
      cycle(1'b1, 32'h14, 32'hB4, 1'b0, 1'b0);
      chk("s2_occ_full", 32'(occupancy), 32'd2);
      chk("s2_pc_held",  out_pc, 32'h10);
      cycle(1'b1, 32'h18, 32'hB8, 1'b0, 1'b0);   // refused: buffer full
      chk("s2_pc_still", out_pc, 32'h10);
      cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      chk("s2_pc_second", out_pc, 32'h14);
      chk("s2_instr_second", out_instr, 32'hB4);
      cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      chk("s2_empty", 32'(occupancy), 32'd0);

      // 3) Flush while full: bubble, rewound PC, incoming word dropped.
      cycle(1'b1, 32'h20, 32'hC0, 1'b0, 1'b0);
      cycle(1'b1, 32'h24, 32'hC4, 1'b0, 1'b0);
      cycle(1'b1, 32'h40, 32'hC8, 1'b0, 1'b1);
      chk("s3_out_valid", 32'(out_valid), 32'd0);
      chk("s3_out_pc",    out_pc, 32'h3F);
      chk("s3_out_instr", out_instr, NOP);
      chk("s3_occ",       32'(occupancy), 32'd0);
      chk("s3_pc_nodec",  out_pc0, 32'h40);
      in_valid = 1'b0; flush = 1'b0;
      #1;
      chk("s3_in_ready", 32'(in_ready), 32'd1);

      // 4) Flush at PC 0 wraps; the no-rewind instance keeps 0.
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      chk("s4_wrap_pc",  out_pc, 32'hFFFF_FFFF);
      chk("s4_nodec_pc", out_pc0, 32'd0);

      // 5) Asynchronous reset mid-cycle while full.
      cycle(1'b1, 32'h50, 32'hD0, 1'b0, 1'b0);
      cycle(1'b1, 32'h54, 32'hD4, 1'b0, 1'b0);
      chk("s5_full", 32'(occupancy), 32'd2);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("s5_out_valid", 32'(out_valid), 32'd0);
      chk("s5_out_pc",    out_pc, 32'd0);
      chk("s5_out_instr", out_instr, NOP);
      chk("s5_occ",       32'(occupancy), 32'd0);
      chk("s5_in_ready",  32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("s5_in_ready_hold", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      chk("s5_in_ready_rel", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // 6) Random traffic against the model.
      for (int i = 0; i < 10000; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), $urandom(), $urandom(),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
